atm_account_arbiter: RTL



---
 rtl/atm_account_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter granting terminals access to a shared balance table,
// with per-card ownership locks and OPEN/READ/WRITE/CLOSE command execution.
module atm_account_arbiter #(
  parameter int N_REQ         = 4,
  parameter int card_width    = 3,
  parameter int balance_width = 20,
  parameter int INIT_BALANCE  = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [2*N_REQ-1:0]               cmd,
  input  logic [N_REQ*card_width-1:0]      card,
  input  logic [N_REQ*balance_width-1:0]   wdata,
  input  logic [N_REQ-1:0]                 abort,
  output logic [N_REQ-1:0]                 ack,
  output logic [balance_width-1:0]         rdata,
  output logic [1:0]                       resp
);

  localparam int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = 1 << card_width;

  localparam logic [1:0] CMD_OPEN  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_CLOSE = 2'b11;

  localparam logic [1:0] RESP_OK        = 2'b00;
  localparam logic [1:0] RESP_LOCKED    = 2'b01;
  localparam logic [1:0] RESP_NOT_OWNER = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                    state;
  logic [IDXW-1:0]           ptr;
  logic [IDXW-1:0]           pick;
  logic                      pick_vld;
  logic [IDXW-1:0]           win_p1;
  logic [1:0]                cmd_p1;
  logic [card_width-1:0]     card_p1;
  logic [balance_width-1:0]  wdata_p1;
  logic [balance_width-1:0]  bal     [DEPTH];
  logic                      lock_v  [DEPTH];
  logic [IDXW-1:0]           lock_id [DEPTH];
  logic                      owned;

  // Scan downward so the port closest above ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        pick     = IDXW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owned = lock_v[card_p1] && (lock_id[card_p1] == win_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win_p1   <= '0;
      cmd_p1   <= '0;
      card_p1  <= '0;
      wdata_p1 <= '0;
      ack      <= '0;
      rdata    <= '0;
      resp     <= RESP_OK;
      for (int j = 0; j < DEPTH; j++) begin
        bal[j]     <= balance_width'(INIT_BALANCE);
        lock_v[j]  <= 1'b0;
        lock_id[j] <= '0;
      end
    end else begin
      ack <= '0;
      case (state)
        // Grant stage: latch winner and its request fields.
        IDLE: begin
          if (pick_vld) begin
            win_p1   <= pick;
            cmd_p1   <= cmd[2*int'(pick) +: 2];
            card_p1  <= card[card_width*int'(pick) +: card_width];
            wdata_p1 <= wdata[balance_width*int'(pick) +: balance_width];
            state    <= EXEC;
          end
        end
        // Execute stage: table lookup/update and registered result.
        EXEC: begin
          state <= RESP;
          ack   <= N_REQ'(1) << win_p1;
          rdata <= '0;
          if (cmd_p1 == CMD_OPEN) begin
            if (!lock_v[card_p1] || owned) begin
              resp  <= RESP_OK;
              rdata <= bal[card_p1];
              if (!abort[win_p1]) begin
                lock_v[card_p1]  <= 1'b1;
                lock_id[card_p1] <= win_p1;
              end
            end else begin
              resp <= RESP_LOCKED;
            end
          end else if (!owned) begin
            resp <= RESP_NOT_OWNER;
          end else begin
            resp <= RESP_OK;
            case (cmd_p1)
              CMD_WRITE: begin
                bal[card_p1] <= wdata_p1;
                rdata        <= wdata_p1;
              end
              CMD_CLOSE: begin
                lock_v[card_p1] <= 1'b0;
                rdata           <= bal[card_p1];
              end
              default: rdata <= bal[card_p1];
            endcase
          end
        end
        // Response stage: ack is visible this cycle; advance the rotation.
        RESP: begin
          state <= IDLE;
          if (win_p1 == IDXW'(N_REQ - 1)) ptr <= '0;
          else                            ptr <= win_p1 + IDXW'(1);
        end
        default: state <= IDLE;
      endcase
      // Placed last so an abort overrides any lock set by the command above.
      for (int j = 0; j < DEPTH; j++) begin
        if (lock_v[j] && abort[lock_id[j]]) lock_v[j] <= 1'b0;
      end
    end
  end

endmodule
